// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed BCD digit scanner for a shared seven-segment
//            decoder, with double-buffered digit updates at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    output logic [3:0]              seg_value,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] c_pre_last = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] c_idx_last = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_pre;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_pending;

    logic                    w_pre_wrap;
    logic                    w_boundary;
    logic                    w_xfer;
    logic                    w_apply;
    logic [NUM_DIGITS:1]     w_zero_from;
    logic [NUM_DIGITS-1:0]   w_blank_vec;
    logic [3:0]              w_digit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_blank_cur;

    assign load_ready = ~r_pending;
    assign w_xfer     = load_valid & ~r_pending;
    assign w_pre_wrap = enable & (r_pre == c_pre_last);
    assign w_boundary = w_pre_wrap & (r_idx == c_idx_last);
    // Disabling the scan also flushes a pending set so re-enable starts fresh.
    assign w_apply    = r_pending & (w_boundary | ~enable);

    // A digit is a leading zero only if it and every more significant digit are 0.
    assign w_zero_from[NUM_DIGITS] = 1'b1;
    assign w_blank_vec[0]          = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
            assign w_zero_from[gi] = (r_active[4*gi +: 4] == 4'd0) & w_zero_from[gi+1];
            assign w_blank_vec[gi] = blank_lz & w_zero_from[gi];
        end
    endgenerate

    always_comb begin
        w_digit     = 4'd0;
        w_onehot    = '0;
        w_blank_cur = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_digit     = r_active[4*i +: 4];
                w_onehot[i] = 1'b1;
                w_blank_cur = w_blank_vec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre       <= '0;
            r_idx       <= '0;
            r_active    <= '0;
            r_shadow    <= '0;
            r_pending   <= 1'b0;
            seg_value   <= 4'd0;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            if (!enable) begin
                r_pre <= '0;
                r_idx <= '0;
            end else if (w_pre_wrap) begin
                r_pre <= '0;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end

            // Transfer requires pending=0 and apply requires pending=1, so
            // a load coinciding with a boundary waits for the next one.
            if (w_apply) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (w_xfer) begin
                r_shadow  <= load_bcd;
                r_pending <= 1'b1;
            end

            seg_value   <= w_blank_cur ? 4'hF : w_digit;
            dig_en      <= (enable & ~w_blank_cur) ? w_onehot : '0;
            frame_start <= enable & (r_idx == '0) & (r_pre == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Directed self-checking bench for seg_scan_ctrl (2 digits, div 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       blank_lz = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_bcd = 8'h00;
    logic [3:0] seg_value;
    logic [1:0] dig_en;
    logic       frame_start;

    int n_vec = 0;
    int n_err = 0;
    bit m_pend = 1'b0;

    seg_scan_ctrl #(.NUM_DIGITS(2), .SCAN_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .blank_lz    (blank_lz),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_bcd    (load_bcd),
        .seg_value   (seg_value),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 8-cycle frame starting from idx=0/pre=0 with enable high;
    // optional single-cycle load offered before tick load_at.
    task automatic frame(input logic [1:0] e0, input logic [3:0] s0,
                         input logic [1:0] e1, input logic [3:0] s1,
                         input int load_at, input logic [7:0] bcd);
        bit was;
        for (int k = 0; k < 8; k++) begin
            if (k == load_at) begin
                load_valid = 1'b1;
                load_bcd   = bcd;
            end
            tick();
            was = m_pend;
            if (k == 7 && was) m_pend = 1'b0;
            if (k == load_at && !was) m_pend = 1'b1;
            load_valid = 1'b0;
            load_bcd   = 8'hFF;
            chk($sformatf("dig_en[%0d]", k), dig_en, (k < 4) ? e0 : e1);
            chk($sformatf("seg_value[%0d]", k), seg_value, (k < 4) ? s0 : s1);
            chk($sformatf("frame_start[%0d]", k), frame_start, (k == 0) ? 1 : 0);
            chk($sformatf("load_ready[%0d]", k), load_ready, !m_pend);
        end
    endtask

    initial begin
        // Reset and idle
        tick();
        tick();
        chk("rst dig_en", dig_en, 0);
        chk("rst seg_value", seg_value, 0);
        chk("rst frame_start", frame_start, 0);
        chk("rst load_ready", load_ready, 1);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle dig_en", dig_en, 0);
        chk("idle seg_value", seg_value, 0);
        chk("idle frame_start", frame_start, 0);
        chk("idle load_ready", load_ready, 1);

        // Load 42 while disabled: applied on the next edge
        load_valid = 1'b1;
        load_bcd   = 8'h42;
        tick();
        load_valid = 1'b0;
        load_bcd   = 8'hFF;
        chk("load42 ready0", load_ready, 0);
        chk("load42 dark", dig_en, 0);
        tick();
        chk("load42 ready1", load_ready, 1);
        tick();
        chk("dis seg shows d0", seg_value, 4'h2);
        chk("dis still dark", dig_en, 0);
        enable = 1'b1;
        frame(2'b01, 4'h2, 2'b10, 4'h4, -1, 8'h00);
        frame(2'b01, 4'h2, 2'b10, 4'h4, -1, 8'h00);

        // Disable mid digit 1, then re-enable: full frame from digit 0
        repeat (5) tick();
        enable = 1'b0;
        tick();
        chk("mid-dis dig_en", dig_en, 0);
        chk("mid-dis seg", seg_value, 4'h4);
        enable = 1'b1;
        frame(2'b01, 4'h2, 2'b10, 4'h4, -1, 8'h00);

        // Load 57 during cycle 1 of digit 0: current frame keeps 42
        frame(2'b01, 4'h2, 2'b10, 4'h4, 1, 8'h57);
        frame(2'b01, 4'h7, 2'b10, 4'h5, -1, 8'h00);

        // Leading-zero blanking
        blank_lz = 1'b1;
        frame(2'b01, 4'h7, 2'b10, 4'h5, 0, 8'h05);
        frame(2'b01, 4'h5, 2'b00, 4'hF, 0, 8'h00);
        frame(2'b01, 4'h0, 2'b00, 4'hF, -1, 8'h00);
        blank_lz = 1'b0;
        frame(2'b01, 4'h0, 2'b10, 4'h0, -1, 8'h00);

        // Non-BCD digit counts as nonzero; load on the boundary cycle
        blank_lz = 1'b1;
        frame(2'b01, 4'h0, 2'b00, 4'hF, 0, 8'hA3);
        frame(2'b01, 4'h3, 2'b10, 4'hA, 7, 8'h81);
        frame(2'b01, 4'h3, 2'b10, 4'hA, -1, 8'h00);
        frame(2'b01, 4'h1, 2'b10, 4'h8, -1, 8'h00);

        // Async reset mid digit 1 with a pending set
        load_valid = 1'b1;
        load_bcd   = 8'h99;
        tick();
        load_valid = 1'b0;
        load_bcd   = 8'hFF;
        chk("pre-rst ready0", load_ready, 0);
        repeat (4) tick();
        chk("pre-rst dig1", dig_en, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("async dig_en", dig_en, 0);
        chk("async ready", load_ready, 1);
        chk("async seg", seg_value, 0);
        chk("async fs", frame_start, 0);
        m_pend   = 1'b0;
        tick();
        rst_n    = 1'b1;
        blank_lz = 1'b0;
        frame(2'b01, 4'h0, 2'b10, 4'h0, -1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
